// File: rtl/sudoku_board_store.sv
// rtl/sudoku_board_store.sv - Sudoku puzzle ROM, protected game RAM and background solve checker
module sudoku_board_store (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  RomAddr,
    output logic [19:0] RomDat,
    input  logic [1:0]  RamAddr,
    input  logic        RamWriteBit,
    input  logic        RamLoad,
    input  logic [3:0]  RamWrMask,
    input  logic [15:0] RamWrDat,
    output logic [15:0] RamDat,
    output logic        writeRejected,
    output logic        checkBusy,
    output logic        solved
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } chk_state_t;

    logic [19:0] rom_dat_q;
    logic [15:0] ram_dat_q;
    logic [15:0] ram_q  [4];
    logic [3:0]  mask_q [4];
    logic        rejected_q;
    logic        busy_q;
    logic        solved_q;
    chk_state_t  state_q;
    logic [3:0]  idx_q;
    logic        acc_q;

    logic [19:0] rom_word_d;
    logic [15:0] old_row;
    logic [15:0] prot_bits;
    logic [15:0] merged_row_d;
    logic        rejected_d;
    logic [3:0]  dig [4][4];
    logic [3:0]  grp [4];
    logic [3:0]  seen;
    logic        digits_valid;
    logic        grp_ok;
    logic        acc_d;

    // Mask bit 3 is the ROM word's bit 19 and protects the leftmost digit.
    always_comb begin
        rom_word_d = '0;
        case (RomAddr)
            4'd0:  rom_word_d = 20'h91004;
            4'd1:  rom_word_d = 20'h60410;
            4'd2:  rom_word_d = 20'h82000;
            4'd3:  rom_word_d = 20'h10001;
            4'd4:  rom_word_d = 20'hA2040;
            4'd5:  rom_word_d = 20'h50402;
            4'd6:  rom_word_d = 20'hA1030;
            4'd7:  rom_word_d = 20'h50301;
            4'd8:  rom_word_d = 20'hA3010;
            4'd9:  rom_word_d = 20'h50204;
            4'd10: rom_word_d = 20'hA4020;
            4'd11: rom_word_d = 20'h50103;
            4'd12: rom_word_d = 20'hA4020;
            4'd13: rom_word_d = 20'h50103;
            4'd14: rom_word_d = 20'hA3010;
            4'd15: rom_word_d = 20'h50204;
            default: rom_word_d = '0;
        endcase
    end

    always_comb begin
        old_row      = ram_q[RamAddr];
        prot_bits    = {{4{mask_q[RamAddr][3]}}, {4{mask_q[RamAddr][2]}},
                        {4{mask_q[RamAddr][1]}}, {4{mask_q[RamAddr][0]}}};
        merged_row_d = RamLoad ? RamWrDat : ((old_row & prot_bits) | (RamWrDat & ~prot_bits));
        rejected_d   = RamWriteBit && !RamLoad && (|((old_row ^ RamWrDat) & prot_bits));
    end

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                dig[r][c] = ram_q[r][15 - 4*c -: 4];
            end
        end
    end

    // idx[3:2] picks the group kind (row, column, box); idx[1:0] picks which one.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            grp[k] = '0;
        end
        case (idx_q[3:2])
            2'd0: begin
                for (int k = 0; k < 4; k++) grp[k] = dig[idx_q[1:0]][k];
            end
            2'd1: begin
                for (int k = 0; k < 4; k++) grp[k] = dig[k][idx_q[1:0]];
            end
            default: begin
                grp[0] = dig[{idx_q[1], 1'b0}][{idx_q[0], 1'b0}];
                grp[1] = dig[{idx_q[1], 1'b0}][{idx_q[0], 1'b1}];
                grp[2] = dig[{idx_q[1], 1'b1}][{idx_q[0], 1'b0}];
                grp[3] = dig[{idx_q[1], 1'b1}][{idx_q[0], 1'b1}];
            end
        endcase
    end

    // Digit 4 lands on seen[3] through the 2-bit wrap of 0 - 1.
    always_comb begin
        seen         = '0;
        digits_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (grp[k] >= 4'd1 && grp[k] <= 4'd4) begin
                seen[grp[k][1:0] - 2'd1] = 1'b1;
            end else begin
                digits_valid = 1'b0;
            end
        end
        grp_ok = digits_valid && (seen == 4'hF);
        acc_d  = acc_q & grp_ok;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rom_dat_q  <= '0;
            ram_dat_q  <= '0;
            rejected_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                ram_q[i]  <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            rom_dat_q  <= rom_word_d;
            rejected_q <= rejected_d;
            if (RamWriteBit) begin
                ram_q[RamAddr] <= merged_row_d;
                ram_dat_q      <= merged_row_d;
                if (RamLoad) begin
                    mask_q[RamAddr] <= RamWrMask;
                end
            end else begin
                ram_dat_q <= ram_q[RamAddr];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            acc_q    <= 1'b1;
            busy_q   <= 1'b0;
            solved_q <= 1'b0;
        end else if (RamWriteBit) begin
            state_q <= S_SCAN;
            idx_q   <= '0;
            acc_q   <= 1'b1;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                S_SCAN: begin
                    acc_q <= acc_d;
                    if (idx_q == 4'd11) begin
                        solved_q <= acc_d;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign RomDat        = rom_dat_q;
    assign RamDat        = ram_dat_q;
    assign writeRejected = rejected_q;
    assign checkBusy     = busy_q;
    assign solved        = solved_q;

endmodule
